// File: rtl/mips_pkg.sv
// mips_pkg: fetch state encoding, reset PC default and opcodes shared by fetch and control.
package mips_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE, HALT} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus plus the decode valid/ready and control bundle.
interface fetch_unit_if #(parameter int ADDR_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus4_out;
  logic              decode_ready;
  logic              BranchEQ, BranchNE, J, JR, Jal, Zero;
  logic [ADDR_W-1:0] jr_addr;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4_out,
    input  imem_ack, imem_rdata, decode_ready, BranchEQ, BranchNE, J, JR, Jal, Zero, jr_addr
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4_out,
    output imem_ack, imem_rdata, decode_ready, BranchEQ, BranchNE, J, JR, Jal, Zero, jr_addr
  );
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC select (JR > J/Jal > taken branch > pc+4) and JR alignment check.
module next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       instr,
  input  logic              BranchEQ,
  input  logic              BranchNE,
  input  logic              J,
  input  logic              JR,
  input  logic              Jal,
  input  logic              Zero,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign
);
  logic [ADDR_W-1:0] pc4, br_tgt, j_tgt;
  always_comb begin
    pc4      = pc + ADDR_W'(4);
    br_tgt   = pc4 + ADDR_W'($signed({instr[15:0], 2'b00}));
    j_tgt    = {pc4[ADDR_W-1:28], instr, 2'b00};
    next_pc  = JR ? jr_addr :
               (J | Jal) ? j_tgt :
               ((BranchEQ & Zero) | (BranchNE & ~Zero)) ? br_tgt : pc4;
    misalign = JR & |jr_addr[1:0];
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS fetch stage feeding decode over valid/ready from a variable-latency req/ack memory.
// FETCH_PERF_CNT_EN adds instr_count/stall_count outputs.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  output logic         align_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  instr_count,
  output logic [31:0]  stall_count
`endif
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d, req_q, req_d, fault_q, fault_d, misalign;
  next_pc_calc #(.ADDR_W(ADDR_W)) u_npc (
    .pc       (pc_q),
    .instr    (instr_q[25:0]),
    .BranchEQ (bus.BranchEQ),
    .BranchNE (bus.BranchNE),
    .J        (bus.J),
    .JR       (bus.JR),
    .Jal      (bus.Jal),
    .Zero     (bus.Zero),
    .jr_addr  (bus.jr_addr),
    .next_pc  (next_pc),
    .misalign (misalign)
  );
  // req_q is low for the first FETCH cycle after reset, so nothing is captured until the request is visible
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      FETCH: if (req_q) begin
        state_d = bus.imem_ack ? ISSUE : WAIT;
        instr_d = bus.imem_ack ? bus.imem_rdata : instr_q;
      end
      WAIT: if (bus.imem_ack) begin
        state_d = ISSUE;
        instr_d = bus.imem_rdata;
      end
      ISSUE: if (bus.decode_ready) begin
        state_d = misalign ? HALT : FETCH;
        pc_d    = misalign ? pc_q : next_pc;
        fault_d = fault_q | misalign;
      end
      HALT: ;
    endcase
    req_d   = (state_d == FETCH) || (state_d == WAIT);
    valid_d = state_d == ISSUE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end
  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.instr_valid  = valid_q;
  assign bus.instr_out    = instr_q;
  assign bus.pc_out       = pc_q;
  assign bus.pc_plus4_out = pc_q + ADDR_W'(4);
  assign align_fault      = fault_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] icnt_q, icnt_d, scnt_q, scnt_d;
  always_comb begin
    icnt_d = icnt_q + 32'(valid_q & bus.decode_ready);
    scnt_d = scnt_q + 32'((state_q == WAIT) | ((state_q == ISSUE) & ~bus.decode_ready));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icnt_q <= '0;
      scnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      scnt_q <= scnt_d;
    end
  end
  assign instr_count = icnt_q;
  assign stall_count = scnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, corner sequences and randomized traffic against a next-PC reference model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  ctrl;
    logic        z;
    logic [31:0] jra;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic align_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count, stall_count;
`endif
  always #5 clk = ~clk;
  fetch_unit_if #(.ADDR_W(32)) bus();
  fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .align_fault (align_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_count (instr_count),
    .stall_count (stall_count)
`endif
  );
  int errs = 0;
  int checks = 0;
  logic [31:0] mpc;
  int mic, msc;
  vec_t vt[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_perf();
`ifdef FETCH_PERF_CNT_EN
    chk("instr_count", instr_count, mic);
    chk("stall_count", stall_count, msc);
`endif
  endtask
  // ctrl = {JR, J, Jal, BranchEQ, BranchNE}
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                           input logic [4:0] c, input logic z, input logic [31:0] jra);
    logic [31:0] pc4;
    int off;
    pc4 = pc + 32'd4;
    off = $signed(instr[15:0]);
    if (c[4]) return jra;
    if (c[3] || c[2]) return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
    if ((c[1] && z) || (c[0] && !z)) return pc4 + 32'(off * 4);
    return pc4;
  endfunction
  task automatic set_ctrl(input logic [4:0] c, input logic z, input logic [31:0] jra);
    {bus.JR, bus.J, bus.Jal, bus.BranchEQ, bus.BranchNE} = c;
    bus.Zero = z;
    bus.jr_addr = jra;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    bus.decode_ready = 1'b0;
    set_ctrl(5'b0, 1'b0, 32'h0);
    #1;
    chk_b("rst_req", bus.imem_req, 1'b0);
    chk_b("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr_out, 32'h0);
    chk_b("rst_fault", align_fault, 1'b0);
    chk("rst_pc", bus.pc_out, RST_PC);
    @(negedge clk);
    mpc = RST_PC;
    mic = 0;
    msc = 0;
    chk_perf();
    reset = 1'b1;
  endtask
  task automatic fetch_one(input logic [31:0] w, input int lat);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_b("req_seen", bus.imem_req, 1'b1);
    chk("fetch_addr", bus.imem_addr, mpc);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk_b("wait_req", bus.imem_req, 1'b1);
      chk("wait_addr", bus.imem_addr, mpc);
      chk_b("wait_valid", bus.instr_valid, 1'b0);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = $urandom;
    msc += lat;
    chk_b("issue_valid", bus.instr_valid, 1'b1);
    chk_b("issue_req", bus.imem_req, 1'b0);
    chk("issue_instr", bus.instr_out, w);
    chk("issue_pc", bus.pc_out, mpc);
    chk("issue_pc4", bus.pc_plus4_out, mpc + 32'd4);
  endtask
  task automatic consume(input logic [4:0] c, input logic z, input logic [31:0] jra, input int hold,
                         input logic [31:0] w);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_b("hold_valid", bus.instr_valid, 1'b1);
      chk_b("hold_req", bus.imem_req, 1'b0);
      chk("hold_instr", bus.instr_out, w);
      chk("hold_pc", bus.pc_out, mpc);
    end
    msc += hold;
    set_ctrl(c, z, jra);
    bus.decode_ready = 1'b1;
    @(negedge clk);
    bus.decode_ready = 1'b0;
    set_ctrl(5'($urandom), 1'($urandom), $urandom);
    mic++;
    mpc = ref_next(mpc, w, c, z, jra);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] w, jra, p;
    logic [4:0] c;
    logic z;
    int r, lat, hold;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.decode_ready = 1'b0;
    set_ctrl(5'b0, 1'b0, 32'h0);
    vt[0]  = '{32'h0000_0020, 5'b00000, 1'b0, 32'h0,         32'h0040_0004};
    vt[1]  = '{32'h8C01_0000, 5'b00000, 1'b1, 32'h0,         32'h0040_0008};
    vt[2]  = '{32'h0020_0008, 5'b10000, 1'b0, 32'h0040_0010, 32'h0040_0010};
    vt[3]  = '{32'h1022_FFFC, 5'b00010, 1'b1, 32'h0,         32'h0040_0004};
    vt[4]  = '{32'h0020_0008, 5'b10000, 1'b0, 32'h0040_0010, 32'h0040_0010};
    vt[5]  = '{32'h1022_FFFC, 5'b00010, 1'b0, 32'h0,         32'h0040_0014};
    vt[6]  = '{32'h0020_0008, 5'b10000, 1'b1, 32'h0040_0020, 32'h0040_0020};
    vt[7]  = '{32'h0810_0040, 5'b01000, 1'b0, 32'h0,         32'h0040_0100};
    vt[8]  = '{32'h0810_0040, 5'b11000, 1'b0, 32'h0040_0200, 32'h0040_0200};
    vt[9]  = '{32'h1422_0010, 5'b00001, 1'b0, 32'h0,         32'h0040_0244};
    vt[10] = '{32'h1422_0010, 5'b00001, 1'b1, 32'h0,         32'h0040_0248};
    vt[11] = '{32'h0C00_0010, 5'b00100, 1'b0, 32'h0,         32'h0000_0040};
    vt[12] = '{32'h1022_8000, 5'b00010, 1'b1, 32'h0,         32'hFFFE_0044};
    vt[13] = '{32'h0020_0008, 5'b10000, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vt[14] = '{32'h0000_0020, 5'b00000, 1'b0, 32'h0,         32'h0000_0000};
    vt[15] = '{32'h0810_0000, 5'b01010, 1'b1, 32'h0,         32'h0040_0000};
    // zero-wait memory with decode always ready: one instruction every two cycles
    do_reset();
    bus.decode_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk_b("tp_req", bus.imem_req, 1'b1);
        chk_b("tp_valid_lo", bus.instr_valid, 1'b0);
        chk("tp_addr", bus.imem_addr, RST_PC + 32'(4 * (k / 2)));
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hA000_0000 | 32'(k);
      end else begin
        chk_b("tp_valid_hi", bus.instr_valid, 1'b1);
        chk_b("tp_req_lo", bus.imem_req, 1'b0);
        chk("tp_instr", bus.instr_out, 32'hA000_0000 | 32'(k - 1));
        bus.imem_ack = 1'b0;
      end
    end
    @(negedge clk);
    bus.decode_ready = 1'b0;
    mpc = RST_PC + 32'd12;
    mic = 3;
    chk("tp_next_addr", bus.imem_addr, mpc);
    chk_perf();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      fetch_one(vt[i].instr, i % 4);
      consume(vt[i].ctrl, vt[i].z, vt[i].jra, i % 3, vt[i].instr);
      chk("vec_next", bus.imem_addr, vt[i].exp);
      mpc = vt[i].exp;
      chk_perf();
    end
    // decode stalls five cycles in ISSUE
    fetch_one(32'h1234_5678, 3);
    consume(5'b0, 1'b0, 32'h0, 5, 32'h1234_5678);
    chk("stall_next", bus.imem_addr, mpc);
    chk_perf();
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      r = $urandom_range(0, 9);
      c = (r == 0) ? 5'b10000 : (r == 1) ? 5'b01000 : (r == 2) ? 5'b00100 :
          (r < 5) ? 5'b00010 : (r < 7) ? 5'b00001 : (r == 9) ? 5'($urandom) : 5'b0;
      z = 1'($urandom);
      jra = $urandom & 32'hFFFF_FFFC;
      lat = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      fetch_one(w, lat);
      consume(c, z, jra, hold, w);
      chk_perf();
    end
    // misaligned JR halts the fetch stage
    fetch_one(32'h0020_0008, 1);
    p = mpc;
    set_ctrl(5'b10000, 1'b0, 32'h0040_0202);
    bus.decode_ready = 1'b1;
    @(negedge clk);
    bus.decode_ready = 1'b0;
    mic++;
    for (int i = 0; i < 4; i++) begin
      chk_b("halt_fault", align_fault, 1'b1);
      chk_b("halt_req", bus.imem_req, 1'b0);
      chk_b("halt_valid", bus.instr_valid, 1'b0);
      chk("halt_pc", bus.pc_out, p);
      @(negedge clk);
    end
    chk_perf();
    // reset pulse while a request is outstanding
    do_reset();
    fetch_one(32'h0020_0008, 0);
    consume(5'b10000, 1'b0, 32'h0040_0400, 0, 32'h0020_0008);
    chk("jr_addr_out", bus.imem_addr, 32'h0040_0400);
    @(negedge clk);
    chk_b("midwait_req", bus.imem_req, 1'b1);
    do_reset();
    fetch_one(32'hDEAD_0000, 2);
    consume(5'b0, 1'b0, 32'h0, 0, 32'hDEAD_0000);
    chk("post_rst_next", bus.imem_addr, RST_PC + 32'd4);
    chk_perf();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the MIPS control/decode stage.
- Holds the PC and requests instruction words from an instruction memory with variable latency (req/ack handshake).
- Presents one instruction at a time to decode with a valid/ready handshake.
- Computes the next PC from decode's branch/jump outputs and the ALU Zero flag for the instruction being consumed.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  word-aligned fetch address; bits [1:0] always 0.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr_out holds a valid instruction.
- instr_out  out  32  instruction to decode (opcode = [31:26]).
- pc_out  out  ADDR_W  PC of instr_out.
- pc_plus4_out  out  ADDR_W  pc_out+4; Jal link value.
- decode_ready  in  1  decode consumes instr_out this cycle.
- BranchEQ, BranchNE, J, JR, Jal  in  1 each  decode control for instr_out; sampled only on consume.
- Zero  in  1  ALU zero flag for instr_out.
- jr_addr  in  ADDR_W  rs register value for JR.
- align_fault  out  1  sticky; JR target not word-aligned.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=FETCH, instr_valid=0, instr_out=0, align_fault=0.
  - imem_req is a Moore output of state, so it is 0 during reset and rises on the first clk after release.
- States: FETCH, WAIT, ISSUE, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ack: capture imem_rdata into instr_out and go to ISSUE (zero-wait ack is legal).
  - Otherwise go to WAIT.
- WAIT:
  - imem_req=1 and imem_addr=pc held stable.
  - On imem_ack: capture the word and go to ISSUE.
- ISSUE:
  - instr_valid=1; instr_out and pc_out stable until consumed.
  - On decode_ready: pc<=next_pc, instr_valid<=0, go to FETCH.
  - Without decode_ready: hold indefinitely.
- imem_ack in ISSUE or HALT is ignored. Memory must not ack without a request.
- Throughput: minimum 2 cycles per instruction (FETCH with zero-wait ack, then ISSUE).
- next_pc priority, highest first:
  - JR: jr_addr.
  - J or Jal: {pc+4[31:28], instr_out[25:0], 2'b00}.
  - (BranchEQ & Zero) | (BranchNE & ~Zero): pc+4 + (sign-extended instr_out[15:0] << 2).
  - Otherwise: pc+4.
- Arithmetic is mod 2^ADDR_W; wrap-around is silent. No branch delay slot.
- JR with jr_addr[1:0]!=0 on consume: align_fault<=1, pc unchanged, go to HALT.
- HALT: imem_req=0, instr_valid=0. Only reset exits HALT.
- Reset during WAIT abandons the outstanding request; a late ack after reset release is treated as an ack of the new FETCH at RESET_PC. The memory must drop stale acks on reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs instr_count[31:0] and stall_count[31:0].
  - instr_count increments on each consume (instr_valid & decode_ready).
  - stall_count increments on each cycle in WAIT, or in ISSUE without decode_ready.
  - Both counters reset to 0, wrap at 2^32, and freeze in HALT.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - fetch state enum (FETCH, WAIT, ISSUE, HALT).
  - RESET_PC default.
  - Opcode constants shared with control (R_Type, J 6'h02, JAL 6'h03, BEQ 6'h04, BNE 6'h05).
- Sub-module next_pc_calc: purely combinational; inputs pc, instr_out, control bits, Zero, jr_addr; outputs next_pc and misalign.

Test Plan:
- Reset release, imem_ack same cycle, decode_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_valid every second cycle.
- imem_ack delayed 3 cycles -> imem_req and imem_addr stay stable for 4 cycles; instr_out equals imem_rdata from the ack cycle.
- pc=0x00400010, BranchEQ=1, Zero=1, imm=16'hFFFC -> next imem_addr 0x00400004. Same with Zero=0 -> 0x00400014.
- pc=0x00400020, J=1, instr[25:0]=26'h0100040 -> next imem_addr 0x00400100. JR=1 with J=1, jr_addr=0x00400200 -> 0x00400200 (JR wins).
- JR with jr_addr=0x00400202 -> align_fault=1, imem_req=0 thereafter; reset pulse mid-WAIT -> pc=0x00400000, align_fault=0.
- decode_ready held low 5 cycles in ISSUE -> instr_out and pc_out unchanged, no imem_req; stall_count +5 with FETCH_PERF_CNT_EN.
